// File: rtl/rgb_pkg.sv
// Shared types and default parameters for the RGB PWM driver.
// Optional feature macro used by this block: RGB_PWM_FADE_EN.
package rgb_pkg;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } rgb_ch_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } pend_state_e;

    localparam int unsigned PWM_BITS_DEF = 8;
    localparam int unsigned PRESCALE_DEF = 46;
    localparam int unsigned NUM_CH       = 3;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One colour channel: target/active duty registers, optional fade step and PWM compare.
// With RGB_PWM_FADE_EN defined, active walks one step per period toward target.
module rgb_pwm_channel
    import rgb_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrap,
    input  logic                xfer,
    input  logic [PWM_BITS-1:0] xfer_duty,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                pwm,
    output logic                differ_next
);

    logic [PWM_BITS-1:0] target_q, target_d;
    logic [PWM_BITS-1:0] active_q, active_d;
    logic                pwm_q, pwm_d;

    // Next-state for target/active duty and the registered compare
    always_comb begin
        target_d = target_q;
        active_d = active_q;
        if (xfer) begin
            target_d = xfer_duty;
        end else begin
            target_d = target_q;
        end
        // target_d is used so a transfer and its first update land on the same wrap
        if (wrap) begin
`ifdef RGB_PWM_FADE_EN
            if (active_q < target_d) begin
                active_d = active_q + PWM_BITS'(1);
            end else if (active_q > target_d) begin
                active_d = active_q - PWM_BITS'(1);
            end else begin
                active_d = active_q;
            end
`else
            active_d = target_d;
`endif
        end else begin
            active_d = active_q;
        end
        pwm_d       = (cnt < active_q);
        differ_next = (active_d != target_d);
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel PWM LED driver with prescaler, period counter and a one-deep load buffer.
// Define RGB_PWM_FADE_EN to fade each channel one step per period toward its target.
module rgb_pwm
    import rgb_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF,
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    input  logic                load_valid,
    output logic                load_ready,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic                period_tick,
    output logic                busy
);

    localparam int unsigned PRESC_W = $clog2(PRESCALE + 2);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] pend_q [NUM_CH];
    logic [PWM_BITS-1:0] pend_d [NUM_CH];
    logic [PWM_BITS-1:0] duty_in_s [NUM_CH];
    pend_state_e         state_q, state_d;
    logic                load_ready_q, load_ready_d;
    logic                period_tick_q, period_tick_d;
    logic                busy_q, busy_d;
    logic                tick_en_s, wrap_s, accept_s, xfer_s;
    logic [NUM_CH-1:0]   pwm_s;
    logic [NUM_CH-1:0]   differ_s;

    assign duty_in_s[CH_R] = duty_r;
    assign duty_in_s[CH_G] = duty_g;
    assign duty_in_s[CH_B] = duty_b;

    // Prescaler and period counter next-state
    always_comb begin
        tick_en_s = (presc_q == PRESC_W'(PRESCALE));
        if (tick_en_s) begin
            presc_d = '0;
            cnt_d   = cnt_q + PWM_BITS'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
            cnt_d   = cnt_q;
        end
        wrap_s        = tick_en_s && (cnt_q == {PWM_BITS{1'b1}});
        period_tick_d = wrap_s;
    end

    // Pending-buffer FSM: accept a triple in IDLE, hand it to the channels on the next wrap
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        xfer_s   = 1'b0;
        accept_s = load_valid && load_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_PENDING;
                    pend_d  = duty_in_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (wrap_s) begin
                    state_d = ST_IDLE;
                    xfer_s  = 1'b1;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        load_ready_d = (state_d == ST_IDLE);
        // Without fading active always equals target, so differ_s stays low there
        busy_d = (state_d == ST_PENDING) || (|differ_s);
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            load_ready_q  <= 1'b0;
            period_tick_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            load_ready_q  <= load_ready_d;
            period_tick_q <= period_tick_d;
            busy_q        <= busy_d;
            pend_q        <= pend_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wrap        (wrap_s),
            .xfer        (xfer_s),
            .xfer_duty   (pend_q[c]),
            .cnt         (cnt_q),
            .pwm         (pwm_s[c]),
            .differ_next (differ_s[c])
        );
    end

    assign pwm_r       = pwm_s[CH_R];
    assign pwm_g       = pwm_s[CH_G];
    assign pwm_b       = pwm_s[CH_B];
    assign load_ready  = load_ready_q;
    assign period_tick = period_tick_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// Self-checking bench for rgb_pwm (PWM_BITS=4): reference model of duties, buffer and periods.
// Honours RGB_PWM_FADE_EN in its reference model.
module tb_rgb_pwm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] duty_r, duty_g, duty_b;
    logic       load_valid;
    logic       load_ready, pwm_r, pwm_g, pwm_b, period_tick, busy;
    logic [3:0] duty2_r, duty2_g, duty2_b;
    logic       load_valid2;
    logic       load_ready2, pwm2_r, pwm2_g, pwm2_b, period_tick2, busy2;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_active [3];
    int m_target [3];
    int m_pend   [3];
    bit m_pending;
    bit drv_valid;
    int drv_vals [3];

    always #5 clk = ~clk;

    rgb_pwm #(.PWM_BITS(4), .PRESCALE(0)) dut (
        .clk(clk), .rst_n(rst_n), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .load_valid(load_valid), .load_ready(load_ready), .pwm_r(pwm_r), .pwm_g(pwm_g),
        .pwm_b(pwm_b), .period_tick(period_tick), .busy(busy)
    );

    rgb_pwm #(.PWM_BITS(4), .PRESCALE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .duty_r(duty2_r), .duty_g(duty2_g), .duty_b(duty2_b),
        .load_valid(load_valid2), .load_ready(load_ready2), .pwm_r(pwm2_r), .pwm_g(pwm2_g),
        .pwm_b(pwm2_b), .period_tick(period_tick2), .busy(busy2)
    );

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_active[c] = 0; m_target[c] = 0; m_pend[c] = 0;
        end
        m_pending = 1'b0;
    endfunction

    // one rising edge of the reference: wrap first, then the handshake seen at that edge
    function automatic void model_edge(input bit wrap);
        bit ready;
        ready = !m_pending;
        if (wrap) begin
            if (m_pending) begin
                m_target  = m_pend;
                m_pending = 1'b0;
            end
            for (int c = 0; c < 3; c++) begin
`ifdef RGB_PWM_FADE_EN
                if (m_active[c] < m_target[c]) m_active[c] = m_active[c] + 1;
                else if (m_active[c] > m_target[c]) m_active[c] = m_active[c] - 1;
`else
                m_active[c] = m_target[c];
`endif
            end
        end
        if (drv_valid && ready) begin
            m_pend    = drv_vals;
            m_pending = 1'b1;
        end
    endfunction

    function automatic bit model_busy();
        bit b;
        b = m_pending;
        for (int c = 0; c < 3; c++) if (m_active[c] != m_target[c]) b = 1'b1;
        return b;
    endfunction

    task automatic drive(input bit v, input int r, input int g, input int b);
        load_valid = v;
        duty_r = 4'(r); duty_g = 4'(g); duty_b = 4'(b);
        drv_valid = v;
        drv_vals[0] = r; drv_vals[1] = g; drv_vals[2] = b;
    endtask

    task automatic sync_period();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (period_tick === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL sync_period: period_tick got 0 want 1 within 100 cycles");
        else n_pass++;
    endtask

    // one 16-cycle period starting at a period_tick; optional loads at cycle offsets (0 = none)
    task automatic measure_period(input int off1, input int r1, input int g1, input int b1,
                                  input int off2, input int r2, input int g2, input int b2,
                                  input string tag);
        int exp_hi [3];
        int hi [3];
        exp_hi = m_active;
        hi = '{0, 0, 0};
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            model_edge(i == 16);
            hi[0] += int'(pwm_r); hi[1] += int'(pwm_g); hi[2] += int'(pwm_b);
            n_checks++;
            if (period_tick !== (i == 16))
                $display("FAIL %s period_tick@%0d: got %b want %b", tag, i, period_tick, (i == 16));
            else n_pass++;
            n_checks++;
            if (load_ready !== !m_pending)
                $display("FAIL %s load_ready@%0d: got %b want %b", tag, i, load_ready, !m_pending);
            else n_pass++;
            n_checks++;
            if (busy !== model_busy())
                $display("FAIL %s busy@%0d: got %b want %b", tag, i, busy, model_busy());
            else n_pass++;
            if (i == off1) drive(1'b1, r1, g1, b1);
            else if (i == off2) drive(1'b1, r2, g2, b2);
            else drive(1'b0, $urandom_range(15), $urandom_range(15), $urandom_range(15));
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (hi[c] !== exp_hi[c])
                $display("FAIL %s high_count ch%0d: got %0d want %0d", tag, c, hi[c], exp_hi[c]);
            else n_pass++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_checks++;
        if ({pwm_r, pwm_g, pwm_b, period_tick, load_ready, busy} !== 6'b0)
            $display("FAIL %s outputs: got %b want 000000", tag,
                     {pwm_r, pwm_g, pwm_b, period_tick, load_ready, busy});
        else n_pass++;
    endtask

    task automatic release_reset(input string tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (load_ready !== 1'b0) $display("FAIL %s ready_before_edge: got %b want 0", tag, load_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL %s ready_after_edge: got %b want 1", tag, load_ready);
        else n_pass++;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b0, 0, 0, 0);
        duty2_r = 4'd0; duty2_g = 4'd0; duty2_b = 4'd0; load_valid2 = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        release_reset("reset");
        sync_period();
    endtask

    task automatic test_fade();
        measure_period(1, 3, 0, 0, 0, 0, 0, 0, "fade_load");
        for (int p = 0; p < 4; p++) measure_period(0, 0, 0, 0, 0, 0, 0, 0, "fade");
    endtask

    task automatic test_basic();
        measure_period(2, 4, 0, 15, 0, 0, 0, 0, "basic_load");
        for (int p = 0; p < 16; p++) measure_period(0, 0, 0, 0, 0, 0, 0, 0, "basic");
    endtask

    task automatic test_ignore();
        measure_period(3, 4, 5, 6, 9, 9, 9, 9, "ignore_load");
        for (int p = 0; p < 2; p++) measure_period(0, 0, 0, 0, 0, 0, 0, 0, "ignore");
    endtask

    task automatic test_wrap_accept();
        measure_period(15, 12, 3, 7, 0, 0, 0, 0, "wrap_load");
        for (int p = 0; p < 3; p++) measure_period(0, 0, 0, 0, 0, 0, 0, 0, "wrap");
    endtask

    task automatic test_random();
        int o1, o2;
        for (int p = 0; p < 12; p++) begin
            o1 = ($urandom_range(1) == 1) ? $urandom_range(15, 1) : 0;
            o2 = $urandom_range(15, 1);
            measure_period(o1, $urandom_range(15), $urandom_range(15), $urandom_range(15),
                           o2, $urandom_range(15), $urandom_range(15), $urandom_range(15),
                           "random");
        end
    endtask

    task automatic test_reset_mid();
        measure_period(2, 9, 9, 9, 0, 0, 0, 0, "rmid_a");
        measure_period(15, 1, 2, 3, 0, 0, 0, 0, "rmid_b");
        repeat (2) begin
            @(negedge clk);
            model_edge(1'b0);
        end
        n_checks++;
        if (pwm_r !== (m_active[0] > 1))
            $display("FAIL rmid pwm_r_before_reset: got %b want %b", pwm_r, (m_active[0] > 1));
        else n_pass++;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rmid");
        release_reset("rmid");
        sync_period();
        for (int p = 0; p < 2; p++) measure_period(0, 0, 0, 0, 0, 0, 0, 0, "rmid_after");
    endtask

    task automatic test_prescale();
        int gap;
        int hi [3];
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (period_tick2 === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL presc_sync: period_tick got 0 want 1 within 200 cycles");
        else n_pass++;
        for (int t = 0; t < 2; t++) begin
            gap = 0;
            found = 1'b0;
            for (int k = 1; k <= 200 && !found; k++) begin
                @(negedge clk);
                if (period_tick2 === 1'b1) begin
                    found = 1'b1;
                    gap = k;
                end
            end
            n_checks++;
            if (gap !== 48) $display("FAIL presc_gap: got %0d want 48", gap);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (load_ready2 !== 1'b1) $display("FAIL presc_ready: got %b want 1", load_ready2);
        else n_pass++;
        duty2_r = 4'd1; duty2_g = 4'd8; duty2_b = 4'd15; load_valid2 = 1'b1;
        @(negedge clk);
        load_valid2 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (period_tick2 === 1'b1) found = 1'b1;
        end
        hi = '{0, 0, 0};
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            hi[0] += int'(pwm2_r); hi[1] += int'(pwm2_g); hi[2] += int'(pwm2_b);
        end
        n_checks++;
        if (!found || hi[0] !== 3 || hi[1] !== 24 || hi[2] !== 45)
            $display("FAIL presc_high: got %0d/%0d/%0d want 3/24/45", hi[0], hi[1], hi[2]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fade();
        test_basic();
        test_ignore();
        test_wrap_accept();
        test_random();
        test_reset_mid();
        test_prescale();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
